// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised synchronous FIFO with occupancy, threshold flags and sticky errors
module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_TH      = 6,
  parameter int unsigned AE_TH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] FIFO_data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned        DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_TH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_acc;
  logic                  pop_acc;

  assign full         = (fifo_count == DEPTH_C);
  assign empty        = (fifo_count == '0);
  assign almost_full  = (fifo_count >= AF_C);
  assign almost_empty = (fifo_count <= AE_C);

  // A pop frees a slot in the same edge, so a full FIFO still takes a push alongside it.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= FIFO_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      FIFO_data_out <= '0;
      valid_out     <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      valid_out <= pop_acc;
      if (push_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop_acc) begin
        FIFO_data_out <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   fifo_count <= fifo_count + (ADDR_WIDTH + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (ADDR_WIDTH + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && !push_acc) begin
        overflow <= 1'b1;
      end
      if (pop && !pop_acc) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - self-checking bench for fifo_sync_param
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset_L;
  logic [DW-1:0] FIFO_data_in;
  logic          push;
  logic          pop;
  logic [DW-1:0] FIFO_data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          underflow;

  fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_TH(AF), .AE_TH(AE)) dut (
    .clk(clk), .reset_L(reset_L), .FIFO_data_in(FIFO_data_in), .push(push), .pop(pop),
    .FIFO_data_out(FIFO_data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .fifo_count(fifo_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of words plus the few observable registers.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  bit            m_valid, m_ovf, m_udf;

  typedef struct {
    bit            push;
    bit            pop;
    logic [DW-1:0] din;
    int            count;
    logic [DW-1:0] dout;
    bit            valid;
    bit            ovf;
    bit            udf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic model_step(input bit pu, input bit po, input logic [DW-1:0] d);
    bit pop_ok, push_ok;
    pop_ok  = po && (q.size() > 0);
    push_ok = pu && (q.size() < DEPTH || pop_ok);
    m_valid = pop_ok;
    if (pop_ok) m_dout = q.pop_front();
    if (push_ok) q.push_back(d);
    if (pu && !push_ok) m_ovf = 1'b1;
    if (po && !pop_ok) m_udf = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(q.size() >= AF));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(q.size() <= AE));
    chk({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    chk({tag, ".dout"}, 32'(FIFO_data_out), 32'(m_dout));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic step(input string tag, input bit pu, input bit po, input logic [DW-1:0] d);
    push = pu;
    pop = po;
    FIFO_data_in = d;
    @(posedge clk);
    model_step(pu, po, d);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    FIFO_data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    // Directed table: fill, overflow, drain, underflow.
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, 1'b0, 8'hA0 + 8'(i), i + 1, 8'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'hFF, 8, 8'h00, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b0, 1'b1, 8'h00, 7 - i, 8'hA0 + 8'(i), 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 0, 8'hA7, 1'b0, 1'b1, 1'b1});

    do_reset();
    #1;
    chk("reset.count", 32'(fifo_count), 0);
    chk("reset.empty", 32'(empty), 1);
    chk("reset.aempty", 32'(almost_empty), 1);
    chk("reset.full", 32'(full), 0);
    chk("reset.afull", 32'(almost_full), 0);
    chk("reset.dout", 32'(FIFO_data_out), 0);
    chk("reset.valid", 32'(valid_out), 0);
    step("idle", 1'b0, 1'b0, 8'h00);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].push, vecs[i].pop, vecs[i].din);
      chk($sformatf("vec%0d.tcount", i), 32'(fifo_count), 32'(vecs[i].count));
      chk($sformatf("vec%0d.tdout", i), 32'(FIFO_data_out), 32'(vecs[i].dout));
      chk($sformatf("vec%0d.tvalid", i), 32'(valid_out), 32'(vecs[i].valid));
      chk($sformatf("vec%0d.tovf", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d.tudf", i), 32'(underflow), 32'(vecs[i].udf));
    end

    // Wrap: 5 in/out then 6 in/out crosses the pointer rollover.
    do_reset();
    for (int i = 0; i < 5; i++) step("wrap_a_push", 1'b1, 1'b0, 8'h30 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      step("wrap_a_pop", 1'b0, 1'b1, 8'h00);
      chk("wrap_a_data", 32'(FIFO_data_out), 32'(8'h30 + 8'(i)));
    end
    for (int i = 0; i < 6; i++) begin
      step("wrap_b_push", 1'b1, 1'b0, 8'h50 + 8'(i));
      chk("wrap_b_count", 32'(fifo_count), 32'(i + 1));
    end
    for (int i = 0; i < 6; i++) begin
      step("wrap_b_pop", 1'b0, 1'b1, 8'h00);
      chk("wrap_b_data", 32'(FIFO_data_out), 32'(8'h50 + 8'(i)));
    end

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) step("full_fill", 1'b1, 1'b0, 8'hB0 + 8'(i));
    step("full_pp", 1'b1, 1'b1, 8'hB8);
    chk("full_pp.head", 32'(FIFO_data_out), 32'h0B0);
    chk("full_pp.count", 32'(fifo_count), 8);
    chk("full_pp.ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      step("full_drain", 1'b0, 1'b1, 8'h00);
      chk("full_drain.data", 32'(FIFO_data_out), 32'(8'hB1 + 8'(i)));
    end

    // Empty with simultaneous push and pop.
    step("empty_pp", 1'b1, 1'b1, 8'h11);
    chk("empty_pp.udf", 32'(underflow), 1);
    chk("empty_pp.count", 32'(fifo_count), 1);
    chk("empty_pp.valid", 32'(valid_out), 0);
    step("empty_pop", 1'b0, 1'b1, 8'h00);
    chk("empty_pop.data", 32'(FIFO_data_out), 32'h011);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) step("burst", 1'b1, 1'b0, 8'hC0 + 8'(i));
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    chk("async_rst.count", 32'(fifo_count), 0);
    chk("async_rst.empty", 32'(empty), 1);
    chk("async_rst.udf", 32'(underflow), 0);
    chk("async_rst.dout", 32'(FIFO_data_out), 0);
    push = 1'b0;
    pop = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      bit pu, po;
      int bias;
      bias = (i / 50) % 2 == 0 ? 70 : 30;
      pu = ($urandom_range(99) < bias);
      po = ($urandom_range(99) < 100 - bias);
      step("rand", pu, po, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
